// File: rtl/operand_fetch_sched_if.sv
// Operand fetch scheduler bus.
// Bundles the decode request, register-file read ports, write-port snoop and
// operand results.
// slave  : the scheduler, which drives ready/addresses/operands/done.
// master : the environment (decode + register file), which drives the rest.
interface operand_fetch_sched_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
);
    logic              req_valid_i;
    logic [3:0]        req_mask_i;
    logic [IDX_W-1:0]  idx0_i, idx1_i, idx2_i, idx3_i;
    logic              ready_o;
    logic [IDX_W-1:0]  rf_addr_a_o, rf_addr_b_o;
    logic [DATA_W-1:0] rf_data_a_i, rf_data_b_i;
    logic              wr_en_i;
    logic [IDX_W-1:0]  wr_idx_i;
    logic [DATA_W-1:0] wr_data_i;
    logic [DATA_W-1:0] op0_o, op1_o, op2_o, op3_o;
    logic              done_o;

    modport slave (
        input  req_valid_i, req_mask_i, idx0_i, idx1_i, idx2_i, idx3_i,
               rf_data_a_i, rf_data_b_i, wr_en_i, wr_idx_i, wr_data_i,
        output ready_o, rf_addr_a_o, rf_addr_b_o,
               op0_o, op1_o, op2_o, op3_o, done_o
    );

    modport master (
        output req_valid_i, req_mask_i, idx0_i, idx1_i, idx2_i, idx3_i,
               rf_data_a_i, rf_data_b_i, wr_en_i, wr_idx_i, wr_data_i,
        input  ready_o, rf_addr_a_o, rf_addr_b_o,
               op0_o, op1_o, op2_o, op3_o, done_o
    );
endinterface

// File: rtl/operand_fetch_sched.sv
// Operand fetch scheduler.
// Accepts one request of up to four register indices and reads them through
// the register file's two combinational read ports, two distinct indices per
// cycle. Duplicate indices are merged, and register writes are snooped so
// every operand carries the newest value. All operands are returned together
// with a one-cycle done pulse.
// Ports: clk, rst (sync, active-high), bus (operand_fetch_sched_if.slave).
module operand_fetch_sched #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
) (
    input logic                  clk,
    input logic                  rst,
    operand_fetch_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t                   state;
    logic [3:0]               pending, mask_l;
    logic [3:0][IDX_W-1:0]    lidx;
    logic [3:0][DATA_W-1:0]   ops;
    logic                     done_q;

    logic [3:0][IDX_W-1:0]    req_idx;
    logic [1:0]               j, k;
    logic                     has_k;
    logic [IDX_W-1:0]         idx_a, idx_b;
    logic [3:0]               hit_a, hit_b, hit_w, pending_nxt;

    assign req_idx = {bus.idx3_i, bus.idx2_i, bus.idx1_i, bus.idx0_i};

    // j: lowest pending slot. k: lowest pending slot with an index different
    // from slot j, so port B never wastes a read on a duplicate of port A.
    always_comb begin
        j     = '0;
        k     = '0;
        has_k = 1'b0;
        for (int s = 3; s >= 0; s--)
            if (pending[s]) j = 2'(s);
        for (int s = 3; s >= 0; s--)
            if (pending[s] && lidx[s] != lidx[j]) begin
                k     = 2'(s);
                has_k = 1'b1;
            end
        idx_a = lidx[j];
        idx_b = has_k ? lidx[k] : lidx[j];
    end

    // Per-slot capture sources. Snoop applies to every requested slot, even
    // one already captured; port hits only to slots still pending.
    for (genvar g = 0; g < 4; g++) begin : g_slot
        assign hit_w[g] = bus.wr_en_i && mask_l[g] && (bus.wr_idx_i == lidx[g]);
        assign hit_a[g] = pending[g] && (lidx[g] == idx_a);
        assign hit_b[g] = pending[g] && has_k && (lidx[g] == idx_b);
    end

    assign pending_nxt = pending & ~(hit_a | hit_b | hit_w);

    assign bus.ready_o     = (state != READ);
    assign bus.rf_addr_a_o = (state == READ) ? idx_a : '0;
    assign bus.rf_addr_b_o = (state == READ) ? idx_b : '0;
    assign bus.op0_o       = ops[0];
    assign bus.op1_o       = ops[1];
    assign bus.op2_o       = ops[2];
    assign bus.op3_o       = ops[3];
    assign bus.done_o      = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            mask_l  <= '0;
            lidx    <= '0;
            ops     <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    if (bus.req_valid_i) begin
                        pending <= bus.req_mask_i;
                        mask_l  <= bus.req_mask_i;
                        lidx    <= req_idx;
                        // An empty mask still produces a done pulse.
                        state   <= (bus.req_mask_i != 4'b0) ? READ : DONE;
                        done_q  <= (bus.req_mask_i == 4'b0);
                    end
                end
                READ: begin
                    // Snoop wins: the port returns the pre-write value.
                    for (int s = 0; s < 4; s++) begin
                        if (hit_w[s])      ops[s] <= bus.wr_data_i;
                        else if (hit_a[s]) ops[s] <= bus.rf_data_a_i;
                        else if (hit_b[s]) ops[s] <= bus.rf_data_b_i;
                    end
                    pending <= pending_nxt;
                    if (pending_nxt == 4'b0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_fetch_sched.sv
// Self-checking bench for operand_fetch_sched: table of directed requests,
// hand-written snoop / back-to-back / reset sequences, then randomized
// requests scored against a distinct-index queue model.
module tb_operand_fetch_sched;
    localparam int DW = 32;
    localparam int IW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_fetch_sched_if #(.DATA_W(DW), .IDX_W(IW)) bus();
    operand_fetch_sched #(.DATA_W(DW), .IDX_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Register file model: combinational reads, writes land after the edge.
    logic [DW-1:0] rf [64];
    assign bus.rf_data_a_i = rf[bus.rf_addr_a_o];
    assign bus.rf_data_b_i = rf[bus.rf_addr_b_o];

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [3:0]          mask;
        logic [3:0][IW-1:0]  idx;
        logic [3:0]          reads;
        logic [IW-1:0]       a;
        logic [IW-1:0]       b;
        logic [3:0][DW-1:0]  ops;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic [3:0] m, input int i0, i1, i2, i3,
                                input int rd, input int a, b,
                                input logic [DW-1:0] o0, o1, o2, o3);
        vec_t v;
        v.mask  = m;
        v.idx   = {IW'(i3), IW'(i2), IW'(i1), IW'(i0)};
        v.reads = 4'(rd);
        v.a     = IW'(a);
        v.b     = IW'(b);
        v.ops   = {o3, o2, o1, o0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_ops(input string tag, input logic [DW-1:0] e0, e1, e2, e3);
        chk({tag, " op0"}, bus.op0_o, e0);
        chk({tag, " op1"}, bus.op1_o, e1);
        chk({tag, " op2"}, bus.op2_o, e2);
        chk({tag, " op3"}, bus.op3_o, e3);
    endtask

    // One clock; outputs are stable and the write has landed on return.
    // Request and write strobes are one-shot.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.wr_en_i) rf[bus.wr_idx_i] = bus.wr_data_i;
        bus.wr_en_i     = 1'b0;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic drive_req(input logic [3:0] m, input logic [IW-1:0] i0, i1, i2, i3);
        bus.req_valid_i = 1'b1;
        bus.req_mask_i  = m;
        bus.idx0_i      = i0;
        bus.idx1_i      = i1;
        bus.idx2_i      = i2;
        bus.idx3_i      = i3;
    endtask

    task automatic drive_wr(input logic [IW-1:0] i, input logic [DW-1:0] d);
        bus.wr_en_i   = 1'b1;
        bus.wr_idx_i  = i;
        bus.wr_data_i = d;
    endtask

    initial begin
        vec_t v;
        int lat, pulses;
        logic [3:0] m;
        logic [IW-1:0] li [4];
        logic [DW-1:0] eo [4];
        int q[$];
        int nq[$];
        int a, b;
        logic we;
        logic [IW-1:0] wi;
        logic [DW-1:0] wd;

        for (int i = 0; i < 64; i++) rf[i] = 32'h1000 + DW'(i);
        rf[2] = 32'hA;
        rf[5] = 32'hB;

        bus.req_valid_i = 0; bus.req_mask_i = 0;
        bus.idx0_i = 0; bus.idx1_i = 0; bus.idx2_i = 0; bus.idx3_i = 0;
        bus.wr_en_i = 0; bus.wr_idx_i = 0; bus.wr_data_i = 0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset ready", bus.ready_o, 1);
        chk("reset done", bus.done_o, 0);
        chk("reset addr_a", bus.rf_addr_a_o, 0);
        chk("reset addr_b", bus.rf_addr_b_o, 0);
        chk_ops("reset", 0, 0, 0, 0);

        // Directed table
        vecs[0] = mk(4'b0011, 2, 5, 0, 0, 1, 2, 5, 32'hA, 32'hB, 0, 0);
        vecs[1] = mk(4'b1111, 1, 2, 3, 4, 2, 1, 2, 32'h1001, 32'hA, 32'h1003, 32'h1004);
        vecs[2] = mk(4'b1111, 7, 7, 3, 7, 1, 7, 3, 32'h1007, 32'h1007, 32'h1003, 32'h1007);
        vecs[3] = mk(4'b0100, 0, 0, 9, 0, 1, 9, 9, 32'h1007, 32'h1007, 32'h1009, 32'h1007);
        vecs[4] = mk(4'b1010, 0, 6, 0, 6, 1, 6, 6, 32'h1007, 32'h1006, 32'h1009, 32'h1006);
        vecs[5] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 32'h1007, 32'h1006, 32'h1009, 32'h1006);
        vecs[6] = mk(4'b1101, 8, 0, 8, 11, 1, 8, 11, 32'h1008, 32'h1006, 32'h1008, 32'h100B);

        for (int r = 0; r < 7; r++) begin
            v = vecs[r];
            drive_req(v.mask, v.idx[0], v.idx[1], v.idx[2], v.idx[3]);
            tick();
            if (v.reads != 0) begin
                chk($sformatf("vec%0d ready", r), bus.ready_o, 0);
                chk($sformatf("vec%0d addr_a", r), bus.rf_addr_a_o, v.a);
                chk($sformatf("vec%0d addr_b", r), bus.rf_addr_b_o, v.b);
            end
            lat = 1;
            while (!bus.done_o && lat < 20) begin
                tick();
                lat++;
            end
            chk($sformatf("vec%0d latency", r), lat, v.reads + 1);
            chk_ops($sformatf("vec%0d", r), v.ops[0], v.ops[1], v.ops[2], v.ops[3]);
            chk($sformatf("vec%0d done ready", r), bus.ready_o, 1);
            tick();
            chk($sformatf("vec%0d done pulse", r), bus.done_o, 0);
        end

        // Snoop: write R4 in cycle 1, R1 in cycle 2
        drive_req(4'b1111, 1, 2, 3, 4);
        tick();
        chk("snoop c1 addr_a", bus.rf_addr_a_o, 1);
        chk("snoop c1 addr_b", bus.rf_addr_b_o, 2);
        drive_wr(4, 32'h55);
        tick();
        chk("snoop c2 addr_a", bus.rf_addr_a_o, 3);
        chk("snoop c2 addr_b", bus.rf_addr_b_o, 3);
        chk("snoop c2 done", bus.done_o, 0);
        drive_wr(1, 32'h66);
        tick();
        chk("snoop done", bus.done_o, 1);
        chk_ops("snoop", 32'h66, 32'hA, 32'h1003, 32'h55);
        tick();

        // Ignored request during READ, then back-to-back acceptance in DONE
        drive_req(4'b1111, 1, 2, 3, 4);
        tick();
        chk("b2b c1 addr_a", bus.rf_addr_a_o, 1);
        drive_req(4'b1111, 9, 9, 9, 9);
        tick();
        chk("ignore c2 addr_a", bus.rf_addr_a_o, 3);
        chk("ignore c2 addr_b", bus.rf_addr_b_o, 4);
        tick();
        chk("b2b done", bus.done_o, 1);
        chk("b2b ready", bus.ready_o, 1);
        chk_ops("b2b first", 32'h66, 32'hA, 32'h1003, 32'h55);
        drive_req(4'b0001, 10, 0, 0, 0);
        tick();
        chk("b2b accept ready", bus.ready_o, 0);
        chk("b2b accept done", bus.done_o, 0);
        chk("b2b accept addr_a", bus.rf_addr_a_o, 10);
        tick();
        chk("b2b second done", bus.done_o, 1);
        chk_ops("b2b second", 32'h100A, 32'hA, 32'h1003, 32'h55);
        tick();

        // Reset in first READ cycle, with a competing request
        drive_req(4'b1111, 1, 2, 3, 4);
        tick();
        rst = 1'b1;
        drive_req(4'b0000, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        chk("rst mid ready", bus.ready_o, 1);
        chk("rst mid done", bus.done_o, 0);
        chk("rst mid addr_a", bus.rf_addr_a_o, 0);
        chk_ops("rst mid", 0, 0, 0, 0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.done_o) pulses++;
        end
        chk("rst no done", pulses, 0);
        drive_req(4'b0000, 3, 3, 3, 3);
        tick();
        chk("mask0 done", bus.done_o, 1);
        chk_ops("mask0", 0, 0, 0, 0);
        tick();

        // Randomized requests against a distinct-index queue model
        for (int i = 0; i < 4; i++) eo[i] = '0;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 7) == 0) tick();
            m = 4'($urandom);
            for (int s = 0; s < 4; s++) li[s] = IW'($urandom_range(0, 7));
            drive_req(m, li[0], li[1], li[2], li[3]);
            if ($urandom_range(0, 3) == 0)
                drive_wr(IW'($urandom_range(0, 7)), $urandom);
            tick();
            q.delete();
            for (int s = 0; s < 4; s++)
                if (m[s] && !(int'(li[s]) inside {q})) q.push_back(int'(li[s]));
            while (q.size() > 0) begin
                a = q[0];
                b = (q.size() > 1) ? q[1] : q[0];
                chk("rand ready", bus.ready_o, 0);
                chk("rand addr_a", bus.rf_addr_a_o, a);
                chk("rand addr_b", bus.rf_addr_b_o, b);
                for (int s = 0; s < 4; s++)
                    if (m[s] && (int'(li[s]) == a || int'(li[s]) == b)) eo[s] = rf[li[s]];
                we = ($urandom_range(0, 2) == 0);
                wi = IW'($urandom_range(0, 7));
                wd = $urandom;
                if (we) begin
                    drive_wr(wi, wd);
                    for (int s = 0; s < 4; s++)
                        if (m[s] && li[s] == wi) eo[s] = wd;
                end
                nq.delete();
                foreach (q[x])
                    if (q[x] != a && q[x] != b && !(we && q[x] == int'(wi))) nq.push_back(q[x]);
                q = nq;
                if ($urandom_range(0, 3) == 0)
                    drive_req(4'($urandom), IW'($urandom), IW'($urandom), IW'($urandom), IW'($urandom));
                tick();
            end
            chk("rand done", bus.done_o, 1);
            chk_ops("rand", eo[0], eo[1], eo[2], eo[3]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
